// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-side burst consumer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid.sv
// Small output buffer: in-order storage with registered head, one push and one pop per cycle.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             push,
    input  logic [WIDTH:0]   push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occupancy,
    output logic [WIDTH:0]   head
);

    logic [WIDTH:0]   entry_reg  [BUF_DEPTH];
    logic [WIDTH:0]   entry_next [BUF_DEPTH];
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic [OCC_W-1:0] fill_idx;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop & (occ_reg != '0);
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign push_ok = push & ((occ_reg < OCC_W'(BUF_DEPTH)) | pop_ok);
    assign fill_idx = occ_reg - OCC_W'(pop_ok);

    always_comb begin
        entry_next = entry_reg;
        if (pop_ok) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                entry_next[i] = entry_reg[i + 1];
            end
        end
        if (push_ok) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (OCC_W'(i) == fill_idx) begin
                    entry_next[i] = push_data;
                end
            end
        end
        occ_next = occ_reg + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_reg <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            occ_reg   <= occ_next;
            entry_reg <= entry_next;
        end
    end

    assign occupancy = occ_reg;
    assign head      = entry_reg[0];

endmodule

// File: rtl/fifo_rd_burst.sv
// Pops a programmed burst from a show-ahead FIFO read port and streams it out with valid/ready.
module fifo_rd_burst
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    state_t           state_reg,  state_next;
    logic [LEN_W-1:0] len_reg,    len_next;
    logic [LEN_W-1:0] issued_reg, issued_next;
    logic [LEN_W-1:0] count_reg,  count_next;
    logic             done_reg,   done_next;

    logic [OCC_W-1:0] occupancy;
    logic [WIDTH:0]   head;
    logic             accept;
    logic             issue_last;

    assign m_valid    = (occupancy != '0);
    assign m_data     = head[WIDTH-1:0];
    assign m_last     = head[WIDTH];
    assign accept     = m_valid & m_ready;
    assign issue_last = ((issued_reg + LEN_W'(1)) == len_reg);

    // Reset gates the pop so a word is never lost between the FIFO and a clearing buffer.
    assign rinc = ~rrst & (state_reg == RUN) & ~rempty & (issued_reg < len_reg)
                & ((occupancy < OCC_W'(BUF_DEPTH)) | accept);

    fifo_rd_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .rclk      (rclk),
        .rrst      (rrst),
        .push      (rinc),
        .push_data ({issue_last, rdata}),
        .pop       (accept),
        .occupancy (occupancy),
        .head      (head)
    );

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        issued_next = issued_reg;
        count_next  = count_reg;
        done_next   = 1'b0;

        if (rinc) begin
            issued_next = issued_reg + LEN_W'(1);
        end
        if (accept) begin
            count_next = count_reg + LEN_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        len_next    = burst_len;
                        issued_next = '0;
                        count_next  = '0;
                        state_next  = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rinc && issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && m_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            issued_reg <= '0;
            count_reg  <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            issued_reg <= issued_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign count = count_reg;

endmodule
